// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one CPU access at a time, splits
// word-crossing accesses into aligned memory beats and reassembles load data.
module lsu_ctrl #(
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_memop,
  input  logic        req_we,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic [2:0]  mem_memop,
  output logic        mem_we,
  input  logic [31:0] mem_dataout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  memop_q, memop_d;
  logic        we_q, we_d;
  logic [1:0]  beat_q, beat_d;
  logic [31:0] w0_q, w0_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [1:0]  k;
  logic        illegal, misal, err, split;
  logic [1:0]  last_beat;
  logic [31:0] word_a;
  logic [31:0] pair_lo;
  logic [2:0]  tail_memop;
  logic [31:0] tail_data;

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] op);
    logic [31:0] r;
    case (op[1:0])
      2'b00:   r = {{24{v[7] & ~op[2]}}, v[7:0]};
      2'b01:   r = {{16{v[15] & ~op[2]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign k         = addr_q[1:0];
  assign illegal   = (memop_q[1:0] == 2'b11) || (memop_q[2:1] == 2'b11);
  assign misal     = ((memop_q[1:0] == 2'b01) && (k == 2'b11)) ||
                     ((memop_q[1:0] == 2'b10) && (k != 2'b00));
  assign err       = illegal || (misal && (MISALIGN_SPLIT == 0));
  assign split     = misal && !err;
  assign word_a    = {addr_q[31:2], 2'b00};
  assign pair_lo   = 32'({mem_dataout, w0_q} >> {k, 3'b000});
  assign last_beat = !split ? 2'd0 :
                     ((memop_q[1:0] == 2'b10) && (k == 2'b11)) ? 2'd2 : 2'd1;

  // Second store beat carries the bytes spilling past the word, right-justified.
  always_comb begin
    tail_memop = 3'b000;
    tail_data  = 32'h0;
    if (memop_q[1:0] == 2'b10) begin
      case (k)
        2'b01:   begin tail_memop = 3'b000; tail_data = {24'h0, wdata_q[31:24]}; end
        2'b10:   begin tail_memop = 3'b001; tail_data = {16'h0, wdata_q[31:16]}; end
        default: begin tail_memop = 3'b001; tail_data = {16'h0, wdata_q[23:8]};  end
      endcase
    end else begin
      tail_memop = 3'b000;
      tail_data  = {24'h0, wdata_q[15:8]};
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    memop_d    = memop_q;
    we_d       = we_q;
    beat_d     = beat_q;
    w0_d       = w0_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    mem_addr   = 32'h0;
    mem_datain = 32'h0;
    mem_memop  = 3'b000;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          memop_d = req_memop;
          we_d    = req_we;
          beat_d  = 2'd0;
          err_d   = 1'b0;
          rdata_d = 32'h0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (err) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (!we_q) begin
          if (!split) begin
            mem_addr  = addr_q;
            mem_memop = memop_q;
            state_d   = WAIT;
          end else begin
            mem_memop = 3'b010;
            if (beat_q == 2'd0) begin
              mem_addr = word_a;
              beat_d   = 2'd1;
            end else begin
              // First word returns while the second address is on the bus.
              mem_addr = word_a + 32'd4;
              w0_d     = mem_dataout;
              state_d  = WAIT;
            end
          end
        end else begin
          mem_we = 1'b1;
          case (beat_q)
            2'd0: begin
              mem_addr   = addr_q;
              mem_memop  = memop_q;
              mem_datain = wdata_q;
            end
            2'd1: begin
              mem_addr   = word_a + 32'd4;
              mem_memop  = tail_memop;
              mem_datain = tail_data;
            end
            default: begin
              mem_addr   = word_a + 32'd6;
              mem_memop  = 3'b000;
              mem_datain = {24'h0, wdata_q[31:24]};
            end
          endcase
          if (beat_q == last_beat) state_d = RESP;
          else                     beat_d  = beat_q + 2'd1;
        end
      end
      WAIT: begin
        rdata_d = split ? extend(pair_lo, memop_q) : mem_dataout;
        state_d = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        state_d    = IDLE;
      end
    endcase

    // Reset silences every output immediately so an aborted store writes nothing more.
    if (rst) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'h0;
      resp_err   = 1'b0;
      mem_addr   = 32'h0;
      mem_datain = 32'h0;
      mem_memop  = 3'b000;
      mem_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      memop_q <= 3'b000;
      we_q    <= 1'b0;
      beat_q  <= 2'd0;
      w0_q    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      memop_q <= memop_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
      w0_q    <= w0_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a byte-addressed memory controller model feeds the DUTs,
// and a byte-level reference model predicts responses, latency and memory.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_memop;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_datain, mem_dataout;
  logic [2:0]  mem_memop;
  logic        req_ready0, resp_valid0, resp_err0, mem_we0;
  logic [31:0] resp_rdata0, mem_addr0, mem_datain0, mem_dataout0;
  logic [2:0]  mem_memop0;

  always #5 clk = ~clk;

  lsu_ctrl #(.MISALIGN_SPLIT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_memop(req_memop), .req_we(req_we),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_memop(mem_memop),
    .mem_we(mem_we), .mem_dataout(mem_dataout));

  // The no-split instance only reads memory; its writes are never applied.
  lsu_ctrl #(.MISALIGN_SPLIT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_memop(req_memop), .req_we(req_we),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .mem_addr(mem_addr0), .mem_datain(mem_datain0), .mem_memop(mem_memop0),
    .mem_we(mem_we0), .mem_dataout(mem_dataout0));

  int checks = 0;
  int errors = 0;
  logic [7:0] memCtl [logic [31:0]];
  logic [7:0] memRef [logic [31:0]];

  int          latA, lat0;
  logic [31:0] rdA, rd0;
  logic        erA, er0;
  logic [31:0] loadQ [$];
  logic [66:0] storeQ [$];

  function automatic logic [7:0] rdCtl(input logic [31:0] a);
    return memCtl.exists(a) ? memCtl[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rdRef(input logic [31:0] a);
    return memRef.exists(a) ? memRef[a] : 8'h00;
  endfunction

  function automatic int sizeOf(input logic [2:0] op);
    return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] signExt(input logic [31:0] v, input int size, input logic zext);
    logic [31:0] r;
    r = v;
    if (!zext && size == 1) r = {{24{v[7]}}, v[7:0]};
    if (!zext && size == 2) r = {{16{v[15]}}, v[15:0]};
    return r;
  endfunction

  // Memory controller: reads the addressed lanes of one word, writes low-lane bytes.
  function automatic logic [31:0] ctlRead(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] base, w;
    base = {a[31:2], 2'b00};
    w = {rdCtl(base + 32'd3), rdCtl(base + 32'd2), rdCtl(base + 32'd1), rdCtl(base)};
    w = w >> (8 * a[1:0]);
    if (op[1:0] == 2'b00) w = w & 32'hFF;
    if (op[1:0] == 2'b01) w = w & 32'hFFFF;
    return signExt(w, sizeOf(op), op[2]);
  endfunction

  task automatic ctlWrite(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
    for (int i = 0; i < sizeOf(op); i++)
      if (int'(a[1:0]) + i < 4) memCtl[a + 32'(i)] = d[8*i +: 8];
  endtask

  always @(posedge clk) begin
    if (mem_we) ctlWrite(mem_addr, mem_memop, mem_datain);
    mem_dataout  <= ctlRead(mem_addr, mem_memop);
    mem_dataout0 <= ctlRead(mem_addr0, mem_memop0);
  end

  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < sizeOf(op); i++) v[8*i +: 8] = rdRef(a + 32'(i));
    return signExt(v, sizeOf(op), op[2]);
  endfunction

  function automatic logic [95:0] window(input logic [31:0] a, input logic useCtl);
    logic [95:0] v;
    logic [31:0] base;
    base = {a[31:2], 2'b00} - 32'd4;
    for (int i = 0; i < 12; i++)
      v[8*i +: 8] = useCtl ? rdCtl(base + 32'(i)) : rdRef(base + 32'(i));
    return v;
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      memCtl[a + 32'(i)] = w[8*i +: 8];
      memRef[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] wd);
    loadQ.delete();
    storeQ.delete();
    latA = 0; lat0 = 0; rdA = 32'h0; rd0 = 32'h0; erA = 1'b0; er0 = 1'b0;
    req_we = we; req_memop = op; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 10 && !req_ready; i++) begin @(posedge clk); #1; end
    check("req_ready_before_accept", 96'(req_ready), 96'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    req_memop = 3'($urandom); req_we = 1'($urandom);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (resp_valid && latA == 0) begin latA = cyc; rdA = resp_rdata; erA = resp_err; end
      if (resp_valid0 && lat0 == 0) begin lat0 = cyc; rd0 = resp_rdata0; er0 = resp_err0; end
      if (mem_we) storeQ.push_back({mem_addr, mem_memop, mem_datain});
      else if (mem_addr != 32'h0) loadQ.push_back(mem_addr);
      @(posedge clk); #1;
    end
  endtask

  task automatic checkOutput(input logic we, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] wd);
    logic illegal, misal, e1, e0;
    int size, k, latExp;
    logic [31:0] ld;
    size    = sizeOf(op);
    k       = int'(a[1:0]);
    illegal = (op == 3'b011) || (op == 3'b110) || (op == 3'b111) || (we && op[1:0] == 2'b11);
    misal   = !illegal && (k + size > 4);
    e1      = illegal;
    e0      = illegal || misal;
    ld      = refLoad(a, op);
    if (e1)       latExp = 2;
    else if (!we) latExp = misal ? 4 : 3;
    else          latExp = !misal ? 2 : (k + size - 4 == 3) ? 4 : 3;
    applyStimulus(we, op, a, wd);
    check("latency",   96'(latA), 96'(latExp));
    check("resp_err",  96'(erA),  96'(e1));
    check("resp_data", 96'(rdA),  96'((e1 || we) ? 32'h0 : ld));
    check("nosplit_latency", 96'(lat0), 96'(e0 ? 2 : latExp));
    check("nosplit_err",     96'(er0),  96'(e0));
    check("nosplit_data",    96'(rd0),  96'((e0 || we) ? 32'h0 : ld));
    if (we && !e1)
      for (int i = 0; i < size; i++) memRef[a + 32'(i)] = wd[8*i +: 8];
    check("memory_window", window(a, 1'b1), window(a, 1'b0));
  endtask

  initial begin
    logic sawResp, sawWe;
    $display("[TB] lsu_ctrl bench start");
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_memop = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    preset(32'h100, 32'h44332211);
    preset(32'h104, 32'h887766F5);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          96'({req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_datain, mem_memop}),
          96'(0));
    rst = 1'b0;
    #1;
    check("ready_after_reset", 96'(req_ready), 96'(1));

    // Aligned word load: single beat at the request address.
    checkOutput(1'b0, 3'b010, 32'h100, 32'h0);
    check("lw100_data", 96'(rdA), 96'(32'h44332211));
    check("lw100_beats", 96'({32'(loadQ.size()), loadQ.size() > 0 ? loadQ[0] : 32'h0}),
          96'({32'd1, 32'h100}));

    // Word-crossing load: two lw beats at the surrounding aligned words.
    checkOutput(1'b0, 3'b010, 32'h102, 32'h0);
    check("lw102_data", 96'(rdA), 96'(32'h66F54433));
    check("lw102_beats", 96'({32'(loadQ.size()), loadQ.size() > 1 ? {loadQ[0], loadQ[1]} : 64'h0}),
          96'({32'd2, 32'h100, 32'h104}));
    check("lw102_nosplit_err", 96'({lat0, 31'h0, er0}), 96'({32'd2, 32'd1}));

    checkOutput(1'b0, 3'b001, 32'h103, 32'h0);
    check("lh103_data", 96'(rdA), 96'(32'hFFFFF544));
    checkOutput(1'b0, 3'b101, 32'h103, 32'h0);
    check("lhu103_data", 96'(rdA), 96'(32'h0000F544));
    checkOutput(1'b0, 3'b000, 32'h104, 32'h0);
    check("lb104_data", 96'(rdA), 96'(32'hFFFFFFF5));

    // Three-beat store: sw, then sh and sb carrying the spilled bytes.
    checkOutput(1'b1, 3'b010, 32'h103, 32'hAABBCCDD);
    check("sw103_nbeats", 96'(storeQ.size()), 96'(3));
    if (storeQ.size() == 3) begin
      check("sw103_beat0", 96'(storeQ[0]), 96'({32'h103, 3'b010, 32'hAABBCCDD}));
      check("sw103_beat1", 96'(storeQ[1]), 96'({32'h104, 3'b001, 32'h0000BBCC}));
      check("sw103_beat2", 96'(storeQ[2]), 96'({32'h106, 3'b000, 32'h000000AA}));
    end
    check("sw103_mem", 96'({ctlRead(32'h100, 3'b010), ctlRead(32'h104, 3'b010)}),
          96'({32'hDD332211, 32'h88AABBCC}));

    // Illegal memop: no beats at all, error response.
    checkOutput(1'b0, 3'b011, 32'h100, 32'h0);
    check("illegal_no_beats", 96'({32'(loadQ.size()), 32'(storeQ.size())}), 96'(0));
    checkOutput(1'b1, 3'b011, 32'h104, 32'h12345678);
    check("illegal_store_no_we", 96'(storeQ.size()), 96'(0));

    // Address wrap across the top of memory.
    preset(32'hFFFFFFFC, $urandom);
    preset(32'h00000000, $urandom);
    checkOutput(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    checkOutput(1'b1, 3'b010, 32'hFFFFFFFF, $urandom);

    // Reset between the two beats of a split store aborts it silently.
    req_we = 1'b1; req_memop = 3'b010; req_addr = 32'h101; req_wdata = 32'h11223344;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_beat0", 96'({mem_we, mem_addr}), 96'({1'b1, 32'h101}));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_no_we_in_reset", 96'(mem_we), 96'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_ready_after_reset", 96'(req_ready), 96'(1));
    sawResp = 1'b0; sawWe = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sawResp |= resp_valid;
      sawWe   |= mem_we;
      @(posedge clk); #1;
    end
    check("abort_no_resp_no_we", 96'({sawResp, sawWe}), 96'(0));
    memRef[32'h101] = 8'h44; memRef[32'h102] = 8'h33; memRef[32'h103] = 8'h22;
    check("abort_memory", window(32'h101, 1'b1), window(32'h101, 1'b0));

    // Random traffic, mostly near 0x100 with some accesses at the top of memory.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                      : 32'h100 + 32'($urandom_range(0, 31));
      checkOutput(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
